// File: rtl/tb_checker.sv
`default_nettype none
// ============================================================================
// tb_checker: multi-channel error aggregator, cycle watchdog, sticky verdict.
// Rev 1.0 | Optional macro TB_CHECKER_DISPLAY_EN adds simulation-only tracing.
// ============================================================================
module tb_checker #(
   parameter int NUM_CH         = 4,
   parameter int CODE_W         = 32,
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 10000,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     test_done,
   input  logic [NUM_CH-1:0]        err_valid,
   input  logic [NUM_CH*CODE_W-1:0] err_code,
   output logic [2:0]               state,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic                     timed_out,
   output logic [CNT_W-1:0]         err_count,
   output logic [CH_W-1:0]          first_ch,
   output logic [CODE_W-1:0]        first_code,
   output logic [CNT_W-1:0]         cycles
);

   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t              cur, nxt;
   logic                clr, count;
   logic [PC_W-1:0]     pop;
   logic [CH_W-1:0]     low_ch;
   logic [CODE_W-1:0]   low_code;
   logic [SUM_W-1:0]    err_sum;
   logic [CNT_W-1:0]    cnt_next, cyc_next;
   logic [CH_W-1:0]     fch_next;
   logic [CODE_W-1:0]   fcode_next;

   // Downward scan so the lowest set lane is the last one written.
   always_comb begin
      pop      = '0;
      low_ch   = '0;
      low_code = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (err_valid[i]) begin
            low_ch   = CH_W'(i);
            low_code = err_code[i*CODE_W +: CODE_W];
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         pop = pop + PC_W'(err_valid[i]);
      end
   end

   always_comb begin
      err_sum    = {1'b0, err_count} + SUM_W'(pop);
      cnt_next   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      cyc_next   = (&cycles) ? cycles : cycles + CNT_W'(1);
      fch_next   = first_ch;
      fcode_next = first_code;
      if ((err_count == '0) && (|err_valid)) begin
         fch_next   = low_ch;
         fcode_next = low_code;
      end
   end

   always_comb begin
      nxt   = cur;
      clr   = 1'b0;
      count = 1'b0;
      case (cur)
         S_IDLE: begin
            if (start) begin
               nxt = S_RUN;
               clr = 1'b1;
            end
         end
         S_RUN: begin
            if (start) begin
               clr = 1'b1;
            end else begin
               count = 1'b1;
               if (test_done)
                  nxt = ((err_count == '0) && (err_valid == '0)) ? S_PASS : S_FAIL;
               else if ((TIMEOUT_CYCLES != 0) && (cycles == TO_LAST))
                  nxt = S_TIMEOUT;
            end
         end
         S_PASS, S_FAIL, S_TIMEOUT: begin
            if (start) begin
               nxt = S_RUN;
               clr = 1'b1;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Verdict flags are registered from the next state to keep outputs flop-driven.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= S_IDLE;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         cur       <= nxt;
         done      <= (nxt == S_PASS) || (nxt == S_FAIL) || (nxt == S_TIMEOUT);
         pass      <= (nxt == S_PASS);
         fail      <= (nxt == S_FAIL) || (nxt == S_TIMEOUT);
         timed_out <= (nxt == S_TIMEOUT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count  <= '0;
         cycles     <= '0;
         first_ch   <= '0;
         first_code <= '0;
      end else if (clr) begin
         err_count  <= '0;
         cycles     <= '0;
         first_ch   <= '0;
         first_code <= '0;
      end else if (count) begin
         err_count  <= cnt_next;
         cycles     <= cyc_next;
         first_ch   <= fch_next;
         first_code <= fcode_next;
      end
   end

   assign state = cur;

`ifdef TB_CHECKER_DISPLAY_EN
   always @(posedge clk) begin
      if (rst_n && count) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (err_valid[i])
               $display("[tb_checker] error ch=%0d code=0x%0h cycles=%0d",
                        i, err_code[i*CODE_W +: CODE_W], cyc_next);
         end
         if (nxt != S_RUN)
            $display("[tb_checker] verdict=%s err_count=%0d first_ch=%0d first_code=0x%0h",
                     nxt.name(), cnt_next, fch_next, fcode_next);
      end
   end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_tb_checker.sv
`default_nettype none
// ============================================================================
// tb_tb_checker: scoreboard bench for tb_checker (default and 8-cycle watchdog).
// Rev 1.0
// ============================================================================
module tb_tb_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_start, a_test_done;
   logic [3:0]   a_err_valid;
   logic [127:0] a_err_code;
   logic [2:0]   a_state;
   logic         a_done, a_pass, a_fail, a_to;
   logic [31:0]  a_ec, a_fc, a_cy;
   logic [1:0]   a_fch;

   logic         w_start, w_test_done;
   logic [3:0]   w_err_valid;
   logic [127:0] w_err_code;
   logic [2:0]   w_state;
   logic         w_done, w_pass, w_fail, w_to;
   logic [31:0]  w_ec, w_fc, w_cy;
   logic [1:0]   w_fch;

   tb_checker dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .test_done(a_test_done),
      .err_valid(a_err_valid), .err_code(a_err_code), .state(a_state),
      .done(a_done), .pass(a_pass), .fail(a_fail), .timed_out(a_to),
      .err_count(a_ec), .first_ch(a_fch), .first_code(a_fc), .cycles(a_cy)
   );

   tb_checker #(.TIMEOUT_CYCLES(8)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(w_start), .test_done(w_test_done),
      .err_valid(w_err_valid), .err_code(w_err_code), .state(w_state),
      .done(w_done), .pass(w_pass), .fail(w_fail), .timed_out(w_to),
      .err_count(w_ec), .first_ch(w_fch), .first_code(w_fc), .cycles(w_cy)
   );

   typedef struct {
      string       name;
      bit          sel;
      logic [2:0]  st;
      logic [31:0] ec;
      logic [31:0] cy;
      logic [1:0]  fch;
      logic [31:0] fc;
   } exp_t;

   exp_t qa[$];
   exp_t qw[$];
   exp_t snap_q[$];
   event snap_ev;
   int   tests = 0;
   int   fails = 0;

   function automatic exp_t mk(string n, bit s, logic [2:0] st, logic [31:0] ec,
                               logic [31:0] cy, logic [1:0] fch, logic [31:0] fc);
      exp_t e;
      e.name = n; e.sel = s; e.st = st; e.ec = ec; e.cy = cy; e.fch = fch; e.fc = fc;
      return e;
   endfunction

   task automatic cmp(string n, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
      end
   endtask

   task automatic check_rec(exp_t e);
      logic [2:0]  st;
      logic        dn, ps, fl, to;
      logic [31:0] ec, cy, fc;
      logic [1:0]  fch;
      if (e.sel) begin
         st = w_state; dn = w_done; ps = w_pass; fl = w_fail; to = w_to;
         ec = w_ec; cy = w_cy; fch = w_fch; fc = w_fc;
      end else begin
         st = a_state; dn = a_done; ps = a_pass; fl = a_fail; to = a_to;
         ec = a_ec; cy = a_cy; fch = a_fch; fc = a_fc;
      end
      cmp({e.name, ".state"},      64'(st),  64'(e.st));
      cmp({e.name, ".done"},       64'(dn),  64'(e.st >= 3'd2));
      cmp({e.name, ".pass"},       64'(ps),  64'(e.st == 3'd2));
      cmp({e.name, ".fail"},       64'(fl),  64'((e.st == 3'd3) || (e.st == 3'd4)));
      cmp({e.name, ".timed_out"},  64'(to),  64'(e.st == 3'd4));
      cmp({e.name, ".err_count"},  64'(ec),  64'(e.ec));
      cmp({e.name, ".cycles"},     64'(cy),  64'(e.cy));
      cmp({e.name, ".first_ch"},   64'(fch), 64'(e.fch));
      cmp({e.name, ".first_code"}, 64'(fc),  64'(e.fc));
   endtask

   // Verdict monitor: a rising done means the DUT is presenting a verdict.
   initial begin
      bit pa, pw;
      pa = 1'b0;
      pw = 1'b0;
      forever begin
         @(negedge clk);
         if (a_done && !pa) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_verdict_a: state=%0d, no verdict expected", a_state);
            end else check_rec(qa.pop_front());
         end
         if (w_done && !pw) begin
            if (qw.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_verdict_w: state=%0d, no verdict expected", w_state);
            end else check_rec(qw.pop_front());
         end
         pa = a_done;
         pw = w_done;
      end
   end

   // Snapshot monitor for non-verdict observation points.
   initial begin
      forever begin
         @(snap_ev);
         while (snap_q.size() > 0) check_rec(snap_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(exp_t e);
      snap_q.push_back(e);
      ->snap_ev;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      a_start = 0; a_test_done = 0; a_err_valid = '0; a_err_code = '0;
      w_start = 0; w_test_done = 0; w_err_valid = '0; w_err_code = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      snap(mk("reset_a", 0, 3'd0, 0, 0, 0, 0));
      snap(mk("reset_w", 1, 3'd0, 0, 0, 0, 0));

      // Clean run: 20 idle cycles then test_done.
      a_start = 1; tick(); a_start = 0;
      repeat (20) tick();
      a_test_done = 1; qa.push_back(mk("pass20", 0, 3'd2, 0, 21, 0, 0));
      tick(); a_test_done = 0;
      a_err_valid = 4'b1111; a_err_code = {4{32'h99}};
      repeat (2) tick();
      a_err_valid = '0;
      snap(mk("pass_sticky", 0, 3'd2, 0, 21, 0, 0));

      // Single error on ch2 at cycle 5; other lanes carry X.
      a_start = 1; tick(); a_start = 0;
      repeat (4) tick();
      a_err_valid = 4'b0100; a_err_code = {32'hx, 32'h0000_DEAD, 32'hx, 32'hx};
      tick(); a_err_valid = '0;
      repeat (2) tick();
      a_test_done = 1; qa.push_back(mk("single_err", 0, 3'd3, 1, 8, 2, 32'hDEAD));
      tick(); a_test_done = 0;

      // Simultaneous errors: lowest lane wins, later burst leaves the latch alone.
      a_start = 1; tick(); a_start = 0;
      a_err_valid = 4'b1010; a_err_code = {32'h33, 32'hBAD, 32'h11, 32'hBAD};
      tick(); a_err_valid = '0;
      tick();
      snap(mk("simul_mid", 0, 3'd1, 2, 2, 1, 32'h11));
      a_err_valid = 4'b1111; a_err_code = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      tick(); a_err_valid = '0;
      a_test_done = 1; qa.push_back(mk("simul_fail", 0, 3'd3, 6, 4, 1, 32'h11));
      tick(); a_test_done = 0;

      // test_done together with an error, then restart.
      a_start = 1; tick(); a_start = 0;
      repeat (2) tick();
      a_test_done = 1; a_err_valid = 4'b0001; a_err_code = {96'h0, 32'h55};
      qa.push_back(mk("done_with_err", 0, 3'd3, 1, 3, 0, 32'h55));
      tick(); a_test_done = 0; a_err_valid = '0;
      a_start = 1; tick(); a_start = 0;
      snap(mk("restart_clear", 0, 3'd1, 0, 0, 0, 0));
      a_start = 1; a_err_valid = 4'b0010; a_err_code = {64'h0, 32'h66, 32'h0};
      tick(); a_start = 0; a_err_valid = '0;
      snap(mk("restart_discard", 0, 3'd1, 0, 0, 0, 0));

      // Asynchronous reset mid-run after three errors.
      a_err_valid = 4'b0001; a_err_code = {96'h0, 32'h7};
      repeat (3) tick();
      a_err_valid = '0;
      snap(mk("pre_reset", 0, 3'd1, 3, 3, 0, 32'h7));
      #1 rst_n = 1'b0;
      #1 snap(mk("async_reset", 0, 3'd0, 0, 0, 0, 0));
      tick();
      rst_n = 1'b1;
      a_err_valid = 4'b1111; a_err_code = {4{32'hEE}};
      repeat (3) tick();
      a_err_valid = '0;
      snap(mk("idle_ignores_err", 0, 3'd0, 0, 0, 0, 0));

      // Watchdog instance (TIMEOUT_CYCLES=8).
      w_start = 1; tick(); w_start = 0;
      qw.push_back(mk("watchdog", 1, 3'd4, 0, 8, 0, 0));
      repeat (12) tick();
      snap(mk("timeout_frozen", 1, 3'd4, 0, 8, 0, 0));
      w_start = 1; tick(); w_start = 0;
      repeat (7) tick();
      w_test_done = 1; qw.push_back(mk("done_beats_timeout", 1, 3'd2, 0, 8, 0, 0));
      tick(); w_test_done = 0;
      repeat (3) tick();
      w_start = 1; tick(); w_start = 0;
      repeat (7) tick();
      w_err_valid = 4'b0010; w_err_code = {64'h0, 32'h77, 32'h0};
      qw.push_back(mk("timeout_with_err", 1, 3'd4, 1, 8, 1, 32'h77));
      tick(); w_err_valid = '0;
      repeat (3) tick();

      for (int i = 0; i < 50 && (qa.size() != 0 || qw.size() != 0); i++) tick();
      cmp("verdicts_pending_a", 64'(qa.size()), 64'd0);
      cmp("verdicts_pending_w", 64'(qw.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tb_checker.md
Name: tb_checker

Overview:
- Parametrised, multi-channel successor to the single-channel clock/error bench helper.
- Aggregates error reports from NUM_CH checker channels.
- Counts errors, latches the first failing channel and its code, and runs a cycle-timeout watchdog.
- Drives a sticky PASS/FAIL/TIMEOUT verdict that every directed bench in test/ instantiates.

Parameters:
- NUM_CH, 4: number of error-reporting channels (>=1).
- CODE_W, 32: width of each channel's error code.
- CNT_W, 32: width of the cycle and error counters.
- TIMEOUT_CYCLES, 10000: RUN cycles before TIMEOUT; 0 disables the watchdog.
- CH_W, derived: $clog2(NUM_CH), forced to 1 when NUM_CH==1.

Ports:
- clk  in  1  bench clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin or restart a test run.
- test_done  in  1  stimulus finished; request verdict.
- err_valid  in  NUM_CH  per-channel error strobe, one error per asserted bit per cycle.
- err_code  in  NUM_CH*CODE_W  per-channel codes; channel i occupies [i*CODE_W +: CODE_W].
- state  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- done  out  1  state is PASS, FAIL or TIMEOUT.
- pass  out  1  state==PASS.
- fail  out  1  state==FAIL or TIMEOUT.
- timed_out  out  1  state==TIMEOUT.
- err_count  out  CNT_W  total errors seen in RUN; saturating.
- first_ch  out  CH_W  channel index of the first error.
- first_code  out  CODE_W  code of the first error.
- cycles  out  CNT_W  RUN cycles elapsed; saturating.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every output and counter is 0. Reset mid-run abandons the run with no verdict.
- All outputs are registered. A verdict is visible the cycle after the deciding edge.
- IDLE:
  - err_valid is ignored.
  - start=1 -> RUN, clearing err_count, first_ch, first_code and cycles.
- RUN, per cycle:
  - cycles increments by 1 and saturates at all-ones.
  - err_count increments by popcount(err_valid) and saturates at 2^CNT_W-1.
  - first error latch: if err_count==0 and any err_valid bit is set, latch the lowest set index into first_ch and that channel's code into first_code.
  - The first latch never changes again until cleared.
- RUN transitions, in priority order:
  - start=1: restart. Counters clear, state stays RUN, err_valid in that cycle is discarded.
  - test_done=1: -> PASS if err_count==0 and err_valid==0 this cycle; else -> FAIL. Errors arriving with test_done are counted and may set the first latch.
  - Watchdog: TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 -> TIMEOUT. Same-cycle errors are still counted. test_done in that cycle wins over the timeout.
- PASS, FAIL, TIMEOUT:
  - Sticky. Counters are frozen and err_valid is ignored.
  - start=1 -> RUN with counters cleared.
- err_code is sampled only when the corresponding err_valid bit is set. X on non-valid lanes is tolerated.
- No combinational path from any input to any output.

Optional Feature:
- Macro: TB_CHECKER_DISPLAY_EN.
- When defined, simulation-only $display calls are added:
  - one line per counted error, giving channel, code and cycles;
  - one summary line on entry to PASS, FAIL or TIMEOUT, giving the verdict, err_count, first_ch and first_code.
- When undefined, no system tasks are compiled and the block is synthesizable.
- Register behaviour is identical either way.

Test Plan:
- Reset then start, 20 idle cycles, then test_done -> PASS next cycle; pass=1, err_count=0, cycles=21.
- Single error: RUN, err_valid=4'b0100 with ch2 code 0xDEAD at cycle 5, then test_done -> FAIL; err_count=1, first_ch=2, first_code=0xDEAD.
- Simultaneous errors: err_valid=4'b1010 with codes ch1=0x11, ch3=0x33 -> first_ch=1, first_code=0x11, err_count=2. A later 4'b1111 gives err_count=6 and the first latch is unchanged.
- Watchdog: TIMEOUT_CYCLES=8, start, no test_done -> TIMEOUT after 8 RUN cycles; fail=1, timed_out=1. Repeat with test_done on cycle 8 -> PASS.
- test_done with a same-cycle error (err_valid=4'b0001) -> FAIL with err_count=1. Then start -> RUN, counters are 0 and done=0.
- Assert rst_n low mid-RUN after 3 errors, between clock edges -> outputs are 0 immediately and state=IDLE. Errors after release while in IDLE are not counted.
